serial_adder: RTL and testbench

// - Bit-serial WIDTH-bit adder: accepts two operands plus carry-in over a valid/ready handshake.
// - Adds LSB-first, one bit per clock, through a single full-adder cell built from two half adders.
// - Returns the WIDTH-bit sum and carry-out over a valid/ready handshake.
// - Area-cheap arithmetic stage that sits directly downstream of the gate-level adder cells and consumes them.
//

---
 rtl/adder_pkg.sv | 20 ++
 rtl/full_adder_cell.sv | 31 +++
 rtl/half_adder.sv | 12 +
 rtl/serial_adder.sv | 136 +++++++++++++
 tb/tb_serial_adder.sv | 250 +++++++++++++++++++++++++
 5 files changed

// File: rtl/adder_pkg.sv
// Shared types and helpers for the bit-serial adder datapath.
package adder_pkg;

  // Controller states; encoding 2'd3 is unused and recovers to S_IDLE.
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  // Width of the bit counter for a given operand width (at least one bit).
  function automatic int cnt_width(input int width);
    if (width > 1) begin
      return $clog2(width);
    end else begin
      return 1;
    end
  endfunction

endpackage

// File: rtl/full_adder_cell.sv
// Full adder built from two half adders; the carries cannot both be high,
// so a plain OR merges them.
module full_adder_cell (
  input  logic a_i,
  input  logic b_i,
  input  logic cin_i,
  output logic sum_o,
  output logic cout_o
);

  logic prop_s;
  logic gen0_s;
  logic gen1_s;

  half_adder u_ha0 (
    .a_i     (a_i),
    .b_i     (b_i),
    .sum_o   (prop_s),
    .carry_o (gen0_s)
  );

  half_adder u_ha1 (
    .a_i     (prop_s),
    .b_i     (cin_i),
    .sum_o   (sum_o),
    .carry_o (gen1_s)
  );

  assign cout_o = gen0_s | gen1_s;

endmodule

// File: rtl/half_adder.sv
// Gate-level half adder: sum = a ^ b, carry = a & b.
module half_adder (
  input  logic a_i,
  input  logic b_i,
  output logic sum_o,
  output logic carry_o
);

  assign sum_o   = a_i ^ b_i;
  assign carry_o = a_i & b_i;

endmodule

// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder. Operands are accepted in IDLE, added LSB-first
// through one full-adder cell over WIDTH clocks, and the result is presented
// in DONE until the consumer takes it.
module serial_adder
  import adder_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = cnt_width(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_cout,
  output logic             busy
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  state_e             state_q,    state_d;
  logic [WIDTH-1:0]   a_q,        a_d;
  logic [WIDTH-1:0]   b_q,        b_d;
  logic [WIDTH-1:0]   sum_q,      sum_d;
  logic               carry_q,    carry_d;
  logic [CNT_W-1:0]   cnt_q,      cnt_d;
  logic [WIDTH-1:0]   out_sum_q,  out_sum_d;
  logic               out_cout_q, out_cout_d;

  logic               fa_sum_s;
  logic               fa_cout_s;
  logic [WIDTH-1:0]   sum_shift_s;

  full_adder_cell u_fa (
    .a_i    (a_q[0]),
    .b_i    (b_q[0]),
    .cin_i  (carry_q),
    .sum_o  (fa_sum_s),
    .cout_o (fa_cout_s)
  );

  // Sum register shifted right with the new sum bit entering at the MSB.
  always_comb begin
    sum_shift_s            = sum_q >> 1;
    sum_shift_s[WIDTH-1]   = fa_sum_s;
  end

  // Next-state logic for the controller and the datapath registers.
  always_comb begin
    state_d    = state_q;
    a_d        = a_q;
    b_d        = b_q;
    sum_d      = sum_q;
    carry_d    = carry_q;
    cnt_d      = cnt_q;
    out_sum_d  = out_sum_q;
    out_cout_d = out_cout_q;

    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          a_d     = in_a;
          b_d     = in_b;
          carry_d = in_cin;
          cnt_d   = '0;
          state_d = S_RUN;
        end else begin
          state_d = S_IDLE;
        end
      end

      S_RUN: begin
        sum_d   = sum_shift_s;
        a_d     = a_q >> 1;
        b_d     = b_q >> 1;
        carry_d = fa_cout_s;
        cnt_d   = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_LAST) begin
          // Capture the finished result so it holds after handoff.
          out_sum_d  = sum_shift_s;
          out_cout_d = fa_cout_s;
          state_d    = S_DONE;
        end else begin
          state_d = S_RUN;
        end
      end

      S_DONE: begin
        if (out_ready) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_DONE;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and datapath registers with asynchronous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      a_q        <= '0;
      b_q        <= '0;
      sum_q      <= '0;
      carry_q    <= 1'b0;
      cnt_q      <= '0;
      out_sum_q  <= '0;
      out_cout_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      a_q        <= a_d;
      b_q        <= b_d;
      sum_q      <= sum_d;
      carry_q    <= carry_d;
      cnt_q      <= cnt_d;
      out_sum_q  <= out_sum_d;
      out_cout_q <= out_cout_d;
    end
  end

  assign in_ready  = (state_q == S_IDLE);
  assign out_valid = (state_q == S_DONE);
  assign busy      = (state_q == S_RUN) || (state_q == S_DONE);
  assign out_sum   = out_sum_q;
  assign out_cout  = out_cout_q;

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder: an arithmetic reference model for the
// WIDTH=8 build checked every cycle, directed literal cases, and random
// operand sweeps on WIDTH=1 and WIDTH=16 builds.
module tb_serial_adder;

  localparam int W = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst_n;
  logic         in_valid, in_ready, in_cin, out_valid, out_ready, out_cout, busy;
  logic [W-1:0] in_a, in_b, out_sum;

  logic         v1, rdy1, cin1, ov1, ordy1, cout1, busy1;
  logic [0:0]   a1, b1, sum1;
  logic         v16, rdy16, cin16, ov16, ordy16, cout16, busy16;
  logic [15:0]  a16, b16, sum16;

  serial_adder #(.WIDTH(W)) u_dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_cin(in_cin), .out_valid(out_valid),
    .out_ready(out_ready), .out_sum(out_sum), .out_cout(out_cout), .busy(busy)
  );

  serial_adder #(.WIDTH(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(v1), .in_ready(rdy1),
    .in_a(a1), .in_b(b1), .in_cin(cin1), .out_valid(ov1),
    .out_ready(ordy1), .out_sum(sum1), .out_cout(cout1), .busy(busy1)
  );

  serial_adder #(.WIDTH(16)) u_dut16 (
    .clk(clk), .rst_n(rst_n), .in_valid(v16), .in_ready(rdy16),
    .in_a(a16), .in_b(b16), .in_cin(cin16), .out_valid(ov16),
    .out_ready(ordy16), .out_sum(sum16), .out_cout(cout16), .busy(busy16)
  );

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  // Reference model for the WIDTH=8 build: queue of {cout,sum} results,
  // a pending flag, and the edge count at which the operands were taken.
  logic [W:0] exp_q[$];
  bit         pending  = 1'b0;
  int         cyc      = 0;
  int         acc_cyc  = 0;
  bit         model_on = 1'b0;

  // Model update on each rising edge, using only the bench's own inputs.
  initial begin
    bit m_valid;
    bit m_acc;
    forever begin
      @(posedge clk);
      m_valid = pending && ((cyc - acc_cyc) >= W);
      m_acc   = in_valid && !pending;
      cyc++;
      if (!rst_n) begin
        pending = 1'b0;
        exp_q.delete();
      end else if (m_valid && out_ready) begin
        pending = 1'b0;
        if (exp_q.size() > 0) void'(exp_q.pop_front());
      end else if (m_acc) begin
        pending = 1'b1;
        acc_cyc = cyc;
        exp_q.push_back({1'b0, in_a} + {1'b0, in_b} + {{W{1'b0}}, in_cin});
      end
    end
  end

  // Per-cycle comparison of the WIDTH=8 outputs against the model.
  initial begin
    bit m_valid;
    forever begin
      @(negedge clk);
      if (rst_n && model_on) begin
        m_valid = pending && ((cyc - acc_cyc) >= W);
        chk("out_valid", {31'd0, out_valid}, {31'd0, m_valid});
        chk("busy", {31'd0, busy}, {31'd0, pending});
        chk("in_ready", {31'd0, in_ready}, {31'd0, !pending});
        if (m_valid && exp_q.size() > 0) begin
          chk("out_sum", {24'd0, out_sum}, {24'd0, exp_q[0][W-1:0]});
          chk("out_cout", {31'd0, out_cout}, {31'd0, exp_q[0][W]});
        end
      end
    end
  end

  // One WIDTH=8 operation: offer, optionally pulse junk during RUN, wait for
  // the result, optionally apply backpressure, then hand it off.
  task automatic op(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin,
                    input int hold, input bit pulse, input bit lit, input logic [W:0] lit_exp);
    int t;
    logic [W-1:0] s0;
    logic c0;
    @(negedge clk);
    in_valid = 1'b1; in_a = a; in_b = b; in_cin = cin;
    t = 0;
    while (!in_ready && t < W + 8) begin
      @(negedge clk);
      t++;
    end
    if (t >= W + 8) begin
      chk("accept_timeout", 32'd0, 32'd1);
      in_valid = 1'b0;
      return;
    end
    @(posedge clk);
    @(negedge clk);
    t = 0;
    while (!out_valid && t < W + 4) begin
      if (pulse && t < 3) begin
        in_valid = 1'b1; in_a = W'($urandom); in_b = W'($urandom); in_cin = 1'($urandom);
      end else begin
        in_valid = 1'b0;
      end
      @(negedge clk);
      t++;
    end
    in_valid = 1'b0;
    chk("latency", t, W);
    if (lit) begin
      chk("lit_sum", {24'd0, out_sum}, {24'd0, lit_exp[W-1:0]});
      chk("lit_cout", {31'd0, out_cout}, {31'd0, lit_exp[W]});
    end
    s0 = out_sum;
    c0 = out_cout;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      chk("bp_valid", {31'd0, out_valid}, 32'd1);
      chk("bp_in_ready", {31'd0, in_ready}, 32'd0);
      chk("bp_sum", {24'd0, out_sum}, {24'd0, s0});
      chk("bp_cout", {31'd0, out_cout}, {31'd0, c0});
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk("handoff", {31'd0, out_valid}, 32'd0);
  endtask

  // Main sequence: reset, directed cases, abort, random sweeps, summary.
  initial begin
    rst_n = 1'b0;
    in_valid = 1'b0; in_a = '0; in_b = '0; in_cin = 1'b0; out_ready = 1'b0;
    v1 = 1'b0; a1 = '0; b1 = '0; cin1 = 1'b0; ordy1 = 1'b0;
    v16 = 1'b0; a16 = '0; b16 = '0; cin16 = 1'b0; ordy16 = 1'b0;
    #1;
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_out_sum", {24'd0, out_sum}, 32'd0);
    chk("rst_out_cout", {31'd0, out_cout}, 32'd0);
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;
    model_on = 1'b1;

    op(8'h0F, 8'h01, 1'b0, 0, 1'b0, 1'b1, 9'h010);
    op(8'hFF, 8'h01, 1'b0, 0, 1'b0, 1'b1, 9'h100);
    op(8'hFF, 8'hFF, 1'b1, 5, 1'b0, 1'b1, 9'h1FF);
    op(8'h3C, 8'h42, 1'b0, 1, 1'b1, 1'b1, 9'h07E);

    // Abort in the middle of RUN: accept, let three bit edges pass, reset.
    @(negedge clk);
    in_valid = 1'b1; in_a = 8'h33; in_b = 8'h5A; in_cin = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("abort_in_ready", {31'd0, in_ready}, 32'd1);
    chk("abort_out_valid", {31'd0, out_valid}, 32'd0);
    chk("abort_busy", {31'd0, busy}, 32'd0);
    chk("abort_out_sum", {24'd0, out_sum}, 32'd0);
    chk("abort_out_cout", {31'd0, out_cout}, 32'd0);
    @(posedge clk);
    #3 rst_n = 1'b1;
    repeat (W + 2) @(negedge clk);
    op(8'h55, 8'hAA, 1'b1, 0, 1'b0, 1'b1, 9'h100);

    for (int i = 0; i < 200; i++) begin
      op(W'($urandom), W'($urandom), 1'($urandom), $urandom_range(0, 3),
         ($urandom_range(0, 4) == 0), 1'b0, '0);
    end

    fork
      begin
        int t;
        logic [1:0] e;
        for (int i = 0; i < 1000; i++) begin
          @(negedge clk);
          v1 = 1'b1; a1 = 1'($urandom); b1 = 1'($urandom); cin1 = 1'($urandom);
          e = {1'b0, a1} + {1'b0, b1} + {1'b0, cin1};
          chk("w1_in_ready", {31'd0, rdy1}, 32'd1);
          @(negedge clk);
          v1 = 1'b0;
          t = 0;
          while (!ov1 && t < 5) begin
            @(negedge clk);
            t++;
          end
          chk("w1_latency", t, 1);
          chk("w1_sum", {31'd0, sum1}, {31'd0, e[0]});
          chk("w1_cout", {31'd0, cout1}, {31'd0, e[1]});
          ordy1 = 1'b1;
          @(negedge clk);
          ordy1 = 1'b0;
          chk("w1_handoff", {31'd0, ov1}, 32'd0);
        end
      end
      begin
        int t;
        logic [16:0] e;
        for (int i = 0; i < 1000; i++) begin
          @(negedge clk);
          v16 = 1'b1; a16 = 16'($urandom); b16 = 16'($urandom); cin16 = 1'($urandom);
          e = {1'b0, a16} + {1'b0, b16} + {16'd0, cin16};
          chk("w16_in_ready", {31'd0, rdy16}, 32'd1);
          @(negedge clk);
          v16 = 1'b0;
          t = 0;
          while (!ov16 && t < 20) begin
            @(negedge clk);
            t++;
          end
          chk("w16_latency", t, 16);
          chk("w16_sum", {16'd0, sum16}, {16'd0, e[15:0]});
          chk("w16_cout", {31'd0, cout16}, {31'd0, e[16]});
          ordy16 = 1'b1;
          @(negedge clk);
          ordy16 = 1'b0;
          chk("w16_handoff", {31'd0, ov16}, 32'd0);
        end
      end
    join

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
